// File: rtl/alu_issue_unit_pkg.sv
// Shared definitions for the ALU issue unit: ALU op codes, RV32I opcode/funct
// constants, FSM states and the instruction decoder.
package alu_issue_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB, S_ERR} state_e;

    typedef enum logic [1:0] {B_RS2, B_IMM_I, B_IMM_U} opb_sel_e;

    typedef struct packed {
        logic     legal;
        logic     a_zero;
        opb_sel_e b_sel;
        alu_op_e  op;
    } decode_t;

    function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic decode_t decode(input logic [31:0] ins);
        decode_t    d;
        logic [6:0] f7;
        logic [2:0] f3;
        f7       = ins[31:25];
        f3       = ins[14:12];
        d.legal  = 1'b0;
        d.a_zero = 1'b0;
        d.b_sel  = B_RS2;
        d.op     = ALU_ADD;
        case (ins[6:0])
            OPC_OP: begin
                d.legal = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
                d.op    = f3_to_op(f3, f7 == F7_ALT);
            end
            OPC_OP_IMM: begin
                d.b_sel = B_IMM_I;
                case (f3)
                    F3_SLL:  d.legal = (f7 == F7_BASE);
                    F3_SR:   d.legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                    default: d.legal = 1'b1;
                endcase
                // ins[30] is an immediate bit except for shift-right variants
                d.op = f3_to_op(f3, (f3 == F3_SR) && (f7 == F7_ALT));
            end
            OPC_LUI: begin
                d.legal  = 1'b1;
                d.a_zero = 1'b1;
                d.b_sel  = B_IMM_U;
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_unit_regfile.sv
// 32x32 architectural register file: two operand read ports, a debug read port
// and one synchronous write port. x0 is hardwired to zero.
module rv_regfile (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  raddr_a_i,
    output logic [31:0] rdata_a_o,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_b_o,
    input  logic [4:0]  dbg_raddr_i,
    output logic [31:0] dbg_rdata_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] regs_q [31:1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o   = (raddr_a_i   == 5'd0) ? '0 : regs_q[raddr_a_i];
        rdata_b_o   = (raddr_b_i   == 5'd0) ? '0 : regs_q[raddr_b_i];
        dbg_rdata_o = (dbg_raddr_i == 5'd0) ? '0 : regs_q[dbg_raddr_i];
    end

endmodule

// File: rtl/alu_issue_unit.sv
// RV32I issue/execute sequencer: accepts OP/OP-IMM/LUI, drives the external
// combinational ALU through registered operands and writes the result to rd.
module alu_issue_unit
    import alu_issue_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] alu_opdA,
    output logic [31:0] alu_opdB,
    output logic [3:0]  alu_op_sel,
    input  logic [31:0] alu_result,
    output logic        done,
    output logic        illegal,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);

    state_e      state_q, state_d;
    logic [31:0] instr_q, opa_q, opb_q, res_q;
    alu_op_e     op_q;
    decode_t     dec;
    logic [31:0] rs1_val, rs2_val, imm_i, imm_u, opb_d;

    assign dec   = decode(instr_q);
    assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_u = {instr_q[31:12], 12'h000};

    always_comb begin
        case (dec.b_sel)
            B_IMM_I: opb_d = imm_i;
            B_IMM_U: opb_d = imm_u;
            default: opb_d = rs2_val;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (instr_valid) state_d = S_READ;
            S_READ:  state_d = dec.legal ? S_EXEC : S_ERR;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_q == S_IDLE);
        done        = (state_q == S_WB);
        illegal     = (state_q == S_ERR);
    end

    // ALU operand registers only move on a legal decode; ERR leaves them untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            op_q    <= ALU_ADD;
            res_q   <= '0;
        end else begin
            if ((state_q == S_IDLE) && instr_valid) instr_q <= instr;
            if ((state_q == S_READ) && dec.legal) begin
                opa_q <= dec.a_zero ? '0 : rs1_val;
                opb_q <= opb_d;
                op_q  <= dec.op;
            end
            if (state_q == S_EXEC) res_q <= alu_result;
        end
    end

    assign alu_opdA   = opa_q;
    assign alu_opdB   = opb_q;
    assign alu_op_sel = op_q;

    rv_regfile u_regfile (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .raddr_a_i   (instr_q[19:15]),
        .rdata_a_o   (rs1_val),
        .raddr_b_i   (instr_q[24:20]),
        .rdata_b_o   (rs2_val),
        .dbg_raddr_i (dbg_raddr),
        .dbg_rdata_o (dbg_rdata),
        .we_i        (state_q == S_WB),
        .waddr_i     (instr_q[11:7]),
        .wdata_i     (res_q)
    );

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Issue/execute sequencer for the RV32I core: accepts one 32-bit instruction over a valid/ready handshake and decodes OP, OP-IMM and LUI. It reads operands from its internal 32×32 register file, drives the opdA/opdB/op_sel inputs of the combinational ALU, captures the result and writes it back to rd. It is the initiator side of the ALU interface and sits between instruction fetch and the ALU instance.

## Interface
Parameters:
- none (XLEN fixed at 32, 32 architectural registers)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction word present on instr
- instr_ready  out  1  unit can accept; high only in IDLE
- instr  in  32  RV32I instruction word
- alu_opdA  out  32  registered ALU operand A
- alu_opdB  out  32  registered ALU operand B
- alu_op_sel  out  4  registered ALU op code (`ADD..`SLTU codes from header.vh)
- alu_result  in  32  combinational ALU output
- done  out  1  one-cycle pulse: instruction retired
- illegal  out  1  one-cycle pulse: instruction rejected
- dbg_raddr  in  5  debug register read address
- dbg_rdata  out  32  combinational debug read of register file (x0 reads 0)

## Operation
- FSM states: IDLE, READ, EXEC, WB, ERR.
- IDLE: instr_ready=1. On instr_valid&&instr_ready at an edge, latch instr and go to READ. Source holds instr_valid and instr stable until accepted; instr_valid while not in IDLE is ignored.
- READ: decode latched word and read rs1/rs2 from the register file.
  - Legal: load alu_opdA/alu_opdB/alu_op_sel registers and go to EXEC.
  - Illegal: go to ERR; ALU output registers are left unchanged.
- Decode:
  - OP (0110011): funct3 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND. funct7=0100000 is legal only with funct3 000 (SUB) and 101 (SRA); any other funct7≠0000000 is illegal.
  - OP-IMM (0010011): opdB is the sign-extended I-immediate. SLLI requires funct7=0000000. SRLI/SRAI are selected by funct7 0000000/0100000; any other value is illegal.
  - LUI (0110111): opdA=0, opdB={instr[31:12],12'b0}, op ADD.
  - Any other opcode is illegal.
- EXEC: ALU operands are stable. alu_result is captured into an internal result register at the end of this cycle.
- WB: done=1. The result register is written to rd at the end of this cycle; writes to x0 are discarded and done still pulses. Next state IDLE.
- ERR: illegal=1, no register write. Next state IDLE.
- x0 reads as 0 always. Writes complete before the next READ, so back-to-back dependent instructions need no forwarding. rs==rd is safe because the read happens in READ, before WB.

## Timing
- Accept edge E0. READ in cycle after E0, EXEC after E1, WB after E2 (done high), rd updated at E3. instr_ready high again in the cycle after E3.
- Throughput: one instruction per 4 cycles. Illegal path: accept → READ → ERR (illegal high) → IDLE, 3 cycles.
- Reset values: state IDLE, instr_ready=1, done=0, illegal=0, alu_opdA=0, alu_opdB=0, alu_op_sel=`ADD, all registers x1..x31=0.
- Reset asserted in any state aborts the instruction with no register write. All outputs take their reset values immediately (asynchronous).
- done and illegal are never high together. Each is high for exactly one cycle per instruction.

## Structure
- Shared header (header.vh) holds the existing ALU op_sel codes, plus new constants for the opcodes (OP, OP_IMM, LUI), the funct3 values and the FSM state encoding.
- One sub-module: rv_regfile. It has two combinational read ports plus the debug read port, and one synchronous write port with x0 write suppression. Its 31 registers are asynchronously reset to 0.
- The top contains the FSM, the decoder, the operand/op registers and the result register.

## Test plan
- Reset → instr_ready=1, done=0, illegal=0, alu_op_sel=`ADD; dbg_rdata=0 for dbg_raddr 0..31.
- 0x00500093 (ADDI x1,x0,5) → alu_opdA=0 and alu_opdB=5 in EXEC, done in 4th cycle, x1=5. Then 0xFFD00113 (ADDI x2,x0,-3) → x2=0xFFFFFFFD.
- 0x402081B3 (SUB x3,x1,x2) → alu_op_sel=`SUB, x3=0x00000008.
- 0x40115213 (SRAI x4,x2,1) → x4=0xFFFFFFFE. SLTU x5,x1,x2 → x5=1.
- 0x00000000 → illegal pulses 1 cycle, done stays 0, no register changes. 0x00700013 (ADDI x0,x0,7) → done pulses, x0 reads 0.
- instr_valid held high during EXEC → not accepted until IDLE. rst_n low during EXEC of ADDI x6,x0,9 → x6 stays 0 and outputs return to reset values immediately.
